// File: rtl/fft_dit4_pkg.sv
// fft_dit4_pkg: widths, rounding constant and complex types for the radix-4 DIT combiner
package fft_dit4_pkg;
  localparam int DATA_WIDTH = 21;
  localparam int TWID_WIDTH = 16;
  localparam int SHIFT = 15;
  localparam int OUT_WIDTH = 23;
  localparam int IN_W = DATA_WIDTH + TWID_WIDTH + 1;
  localparam int S1_W = IN_W + 1;
  localparam int S2_W = IN_W + 2;
  localparam logic [S2_W:0] RND = (S2_W + 1)'(1) << (SHIFT - 1);
  typedef struct packed {
    logic signed [IN_W-1:0] r;
    logic signed [IN_W-1:0] i;
  } cplx_in_t;
  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] r;
    logic signed [OUT_WIDTH-1:0] i;
  } cplx_out_t;
endpackage

// File: rtl/dit4_round_sat.sv
// dit4_round_sat: round-half-up by SHIFT bits then clip one component to OUT_WIDTH
module dit4_round_sat
  import fft_dit4_pkg::*;
(
  input  logic signed [S2_W-1:0]      x,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        clip
);
  // one extra bit so adding RND to a near-full-scale value cannot wrap
  logic [S2_W:0] t;
  logic [S2_W-SHIFT:0] v;
  assign t = {x[S2_W-1], x} + RND;
  assign v = (S2_W - SHIFT + 1)'(t >> SHIFT);
  assign clip = v[S2_W-SHIFT:OUT_WIDTH-1] != {(S2_W - SHIFT - OUT_WIDTH + 2){v[S2_W-SHIFT]}};
  assign y = clip ? {v[S2_W-SHIFT], {(OUT_WIDTH - 1){~v[S2_W-SHIFT]}}} : v[OUT_WIDTH-1:0];
endmodule

// File: rtl/dit4_butterfly_round.sv
// dit4_butterfly_round: 3-stage radix-4 DIT butterfly with rounding, saturation and sticky clip flag
module dit4_butterfly_round
  import fft_dit4_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [IN_W-1:0]      x0_r,
  input  logic signed [IN_W-1:0]      x0_i,
  input  logic signed [IN_W-1:0]      x1_r,
  input  logic signed [IN_W-1:0]      x1_i,
  input  logic signed [IN_W-1:0]      x2_r,
  input  logic signed [IN_W-1:0]      x2_i,
  input  logic signed [IN_W-1:0]      x3_r,
  input  logic signed [IN_W-1:0]      x3_i,
  input  logic                        sat_clr,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] y0_r,
  output logic signed [OUT_WIDTH-1:0] y0_i,
  output logic signed [OUT_WIDTH-1:0] y1_r,
  output logic signed [OUT_WIDTH-1:0] y1_i,
  output logic signed [OUT_WIDTH-1:0] y2_r,
  output logic signed [OUT_WIDTH-1:0] y2_i,
  output logic signed [OUT_WIDTH-1:0] y3_r,
  output logic signed [OUT_WIDTH-1:0] y3_i,
  output logic                        sat_flag
);
  cplx_in_t x [4];
  cplx_out_t y [4];
  logic signed [S1_W-1:0] s_r [4];
  logic signed [S1_W-1:0] s_i [4];
  logic signed [S2_W-1:0] t_r [4];
  logic signed [S2_W-1:0] t_i [4];
  logic signed [OUT_WIDTH-1:0] q_r [4];
  logic signed [OUT_WIDTH-1:0] q_i [4];
  logic [7:0] clip;
  logic v1, v2;
  assign x[0] = '{r: x0_r, i: x0_i};
  assign x[1] = '{r: x1_r, i: x1_i};
  assign x[2] = '{r: x2_r, i: x2_i};
  assign x[3] = '{r: x3_r, i: x3_i};
  // s0=A+C, s1=A-C, s2=B+D, s3=B-D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s_r[k] <= '0;
        s_i[k] <= '0;
      end
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s_r[0] <= S1_W'(x[0].r) + S1_W'(x[2].r);
        s_i[0] <= S1_W'(x[0].i) + S1_W'(x[2].i);
        s_r[1] <= S1_W'(x[0].r) - S1_W'(x[2].r);
        s_i[1] <= S1_W'(x[0].i) - S1_W'(x[2].i);
        s_r[2] <= S1_W'(x[1].r) + S1_W'(x[3].r);
        s_i[2] <= S1_W'(x[1].i) + S1_W'(x[3].i);
        s_r[3] <= S1_W'(x[1].r) - S1_W'(x[3].r);
        s_i[3] <= S1_W'(x[1].i) - S1_W'(x[3].i);
      end
    end
  end
  // Y1 = s1 - j*s3, Y3 = s1 + j*s3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        t_r[k] <= '0;
        t_i[k] <= '0;
      end
    end else begin
      v2 <= v1;
      if (v1) begin
        t_r[0] <= S2_W'(s_r[0]) + S2_W'(s_r[2]);
        t_i[0] <= S2_W'(s_i[0]) + S2_W'(s_i[2]);
        t_r[2] <= S2_W'(s_r[0]) - S2_W'(s_r[2]);
        t_i[2] <= S2_W'(s_i[0]) - S2_W'(s_i[2]);
        t_r[1] <= S2_W'(s_r[1]) + S2_W'(s_i[3]);
        t_i[1] <= S2_W'(s_i[1]) - S2_W'(s_r[3]);
        t_r[3] <= S2_W'(s_r[1]) - S2_W'(s_i[3]);
        t_i[3] <= S2_W'(s_i[1]) + S2_W'(s_r[3]);
      end
    end
  end
  for (genvar k = 0; k < 4; k++) begin : g_rs
    dit4_round_sat u_r (.x(t_r[k]), .y(q_r[k]), .clip(clip[2*k]));
    dit4_round_sat u_i (.x(t_i[k]), .y(q_i[k]), .clip(clip[2*k+1]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sat_flag <= 1'b0;
      for (int k = 0; k < 4; k++) y[k] <= '0;
    end else begin
      out_valid <= v2;
      sat_flag <= (v2 && |clip) || (sat_flag && !sat_clr);
      if (v2)
        for (int k = 0; k < 4; k++) y[k] <= '{r: q_r[k], i: q_i[k]};
    end
  end
  assign y0_r = y[0].r;
  assign y0_i = y[0].i;
  assign y1_r = y[1].r;
  assign y1_i = y[1].i;
  assign y2_r = y[2].r;
  assign y2_i = y[2].i;
  assign y3_r = y[3].r;
  assign y3_i = y[3].i;
endmodule
